dff_bank_arbiter: RTL and testbench
===================================

// Module: dff_bank_arbiter
// PURPOSE
//  Shares one DATA_W-wide D-flip-flop register (q) between NUM_REQ requesters.
//  - Round-robin arbitration; optional bus lock for consecutive captures.
//  - Lock is bounded by a timeout so one requester cannot starve the others.
//  - Sits in front of the shared D register; owns its load enable and mux select.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  DATA_W    8   width of each requester's data and of q
//  LOCK_MAX  4   max consecutive grants to a locking owner (1..255)
// PORTS
//  clk           in   1                single clock; all state updates on posedge
//  sync_reset    in   1                synchronous reset, active-high
//  req           in   NUM_REQ          req[i]=1: requester i wants a capture
//  lock          in   NUM_REQ          lock[i]=1 with grant: keep ownership next cycle
//  d_in          in   NUM_REQ*DATA_W   requester i data in d_in[i*DATA_W +: DATA_W]
//  gnt           out  NUM_REQ          one-hot grant, combinational, same cycle as req
//  q             out  DATA_W           shared register contents
//  q_valid       out  1                1 for one cycle after a capture
//  q_owner       out  clog2(NUM_REQ)   index of requester last captured into q
//  lock_timeout  out  1                1-cycle pulse when a lock is force-released
// BEHAVIOUR
//  Reset (sync_reset=1 at posedge): q=0, q_valid=0, q_owner=0, lock_timeout=0,
//    ptr=0, lock_cnt=0, state=ARB. gnt is forced to 0 while sync_reset=1.
//  gnt: at most one bit set, only for a requester with req=1; gnt=0 when req=0.
//  Capture: at a posedge with gnt[i]=1 -> q<=d_in slice i, q_owner<=i, q_valid<=1.
//    With no grant -> q and q_owner hold, q_valid<=0. Latency req->q is 1 clock.
//  State ARB:
//    - Grant the first i with req[i]=1, searching ptr, ptr+1, ... mod NUM_REQ.
//    - At the edge: ptr<=(i+1) mod NUM_REQ.
//    - If lock[i]=1: state<=LOCKED, owner<=i, lock_cnt<=1.
//    - If LOCK_MAX=1, lock is ignored and state stays ARB.
//  State LOCKED (owner o):
//    - req[o]=1: gnt[o]=1; all other req ignored.
//      - lock[o]=0 -> state<=ARB after this grant.
//      - lock[o]=1, lock_cnt+1==LOCK_MAX -> state<=ARB, lock_timeout<=1 next cycle.
//      - Otherwise lock_cnt<=lock_cnt+1.
//      - ptr<=(o+1) mod NUM_REQ on every LOCKED grant.
//    - req[o]=0: behaves as ARB this cycle (search from ptr=o+1); state<=ARB.
//      A new lock taken in that cycle is honoured (re-enter LOCKED, lock_cnt<=1).
//    - Owner therefore receives at most LOCK_MAX consecutive grants.
//  Wrap-around: ptr NUM_REQ-1 -> 0. lock_cnt never exceeds LOCK_MAX.
//  Reset mid-lock: returns to ARB, ptr=0; any pending lock_timeout is cleared.
//  Simultaneous req on all inputs in ARB: strict rotation 0,1,2,...,NUM_REQ-1,0.
//  lock[i] for an ungranted i has no effect.
// TESTING (NUM_REQ=4, DATA_W=8, LOCK_MAX=4)
//  1. Reset held 2 cycles, req=4'hF: gnt=0 throughout; then q=0, q_valid=0, q_owner=0.
//  2. req=4'hF, no lock, d_in={8'h44,8'h33,8'h22,8'h11} for 8 cycles:
//     gnt=1,2,4,8,1,2,4,8; q=11,22,33,44,11,...; q_valid=1 each cycle.
//  3. req=4'b0101: gnt alternates 0001/0100; q_owner alternates 0/2; idle bits never granted.
//  4. req=4'hF, lock=4'b0010 held: ARB grants 0, then 1 four times (lock_cnt 1..4),
//     lock_timeout pulses once after the 4th capture, next grant is 2.
//  5. LOCKED owner 1, req[1] drops while req=4'b1001: same cycle gnt=4'b1000, state ARB.
//  6. sync_reset asserted during LOCKED: next cycle state=ARB, ptr=0, q=0.
//     With req=4'hF after release, first grant is 0.

Source files
------------

// File: rtl/dff_bank_arbiter_if.sv
// dff_bank_arbiter_if
//   Bundles the requester-side and register-side signals of the shared
//   D-register arbiter so they travel as one port.
//   req/lock/d_in   : requester -> arbiter (one bit / one DATA_W slice per requester)
//   gnt             : one-hot grant, combinational from req
//   q/q_valid       : shared register contents and one-cycle capture strobe
//   q_owner         : index of the requester last captured into q
//   lock_timeout    : one-cycle pulse when a lock is force-released
//   Modport master is the requester/test side, slave is the arbiter.
interface dff_bank_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*DATA_W-1:0] d_in;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         q;
    logic                      q_valid;
    logic [OWN_W-1:0]          q_owner;
    logic                      lock_timeout;

    modport master (
        output req, lock, d_in,
        input  gnt, q, q_valid, q_owner, lock_timeout
    );

    modport slave (
        input  req, lock, d_in,
        output gnt, q, q_valid, q_owner, lock_timeout
    );
endinterface

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter
//   Shares one DATA_W-wide register q between NUM_REQ requesters.
//   Round-robin arbitration with an optional bus lock; a lock is capped at
//   LOCK_MAX consecutive grants so a locking owner cannot starve the others.
//   Ports:
//     clk         : single clock, all state on posedge
//     sync_reset  : synchronous active-high reset
//     bus         : dff_bank_arbiter_if.slave (req, lock, d_in, gnt, q,
//                   q_valid, q_owner, lock_timeout)

// Per-requester data gate: a lane contributes its slice only when granted,
// so the data mux collapses into an OR tree over the lanes.
module dff_bank_lane #(
    parameter int DATA_W = 8
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] d_gated
);
    assign d_gated = sel ? d : '0;
endmodule

module dff_bank_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              sync_reset,
    dff_bank_arbiter_if.slave bus
);
    localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [OWN_W-1:0] LAST_IDX = OWN_W'(NUM_REQ - 1);
    localparam logic [8:0]       LOCK_LIM = 9'(LOCK_MAX);

    typedef enum logic {S_ARB, S_LOCKED} state_t;

    state_t            state;
    logic [OWN_W-1:0]  ptr;       // next round-robin search start
    logic [OWN_W-1:0]  owner;     // lock holder while LOCKED
    logic [7:0]        lock_cnt;  // grants already given to the lock holder

    logic [NUM_REQ-1:0]             gnt_c;
    logic [OWN_W-1:0]               gnt_idx;
    logic                           gnt_any;
    logic                           locked_hit;
    logic [OWN_W-1:0]               ptr_nxt;
    logic [NUM_REQ-1:0][DATA_W-1:0] d_gated;
    logic [DATA_W-1:0]              d_sel;

    // Grant selection. A lock holder still requesting wins outright; otherwise
    // search from ptr. After any grant ptr already points one past the owner,
    // so a lapsed lock naturally falls back to searching from owner+1.
    always_comb begin
        int idx;
        gnt_c      = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        locked_hit = 1'b0;
        idx        = 0;
        if (state == S_LOCKED && bus.req[owner]) begin
            locked_hit = 1'b1;
            gnt_any    = 1'b1;
            gnt_idx    = owner;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!gnt_any && bus.req[OWN_W'(idx)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = OWN_W'(idx);
                end
            end
        end
        if (gnt_any) gnt_c[gnt_idx] = 1'b1;
    end

    // Grant is suppressed during reset so nothing looks granted while the
    // register is being cleared.
    assign bus.gnt = sync_reset ? '0 : gnt_c;

    assign ptr_nxt = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            dff_bank_lane #(.DATA_W(DATA_W)) u_lane (
                .sel     (gnt_c[gi]),
                .d       (bus.d_in[gi*DATA_W +: DATA_W]),
                .d_gated (d_gated[gi])
            );
        end
    endgenerate

    always_comb begin
        d_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) d_sel = d_sel | d_gated[i];
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state            <= S_ARB;
            ptr              <= '0;
            owner            <= '0;
            lock_cnt         <= '0;
            bus.q            <= '0;
            bus.q_valid      <= 1'b0;
            bus.q_owner      <= '0;
            bus.lock_timeout <= 1'b0;
        end else begin
            bus.lock_timeout <= 1'b0;
            if (gnt_any) begin
                bus.q       <= d_sel;
                bus.q_owner <= gnt_idx;
                bus.q_valid <= 1'b1;
                ptr         <= ptr_nxt;
                if (locked_hit) begin
                    if (!bus.lock[gnt_idx]) begin
                        state    <= S_ARB;
                        lock_cnt <= '0;
                    end else if ({1'b0, lock_cnt} + 9'd1 == LOCK_LIM) begin
                        // Cap reached: hand the bus back even though lock is held.
                        state            <= S_ARB;
                        lock_cnt         <= '0;
                        bus.lock_timeout <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + 8'd1;
                    end
                end else if (bus.lock[gnt_idx] && LOCK_MAX > 1) begin
                    // Fresh lock from an arbitrated grant (also covers a lapsed
                    // owner's cycle, where a new lock is honoured).
                    state    <= S_LOCKED;
                    owner    <= gnt_idx;
                    lock_cnt <= 8'd1;
                end else begin
                    state    <= S_ARB;
                    lock_cnt <= '0;
                end
            end else begin
                bus.q_valid <= 1'b0;
                state       <= S_ARB;
                lock_cnt    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dff_bank_arbiter.sv
module tb_dff_bank_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int LM = 4;

    logic clk = 1'b0;
    logic sync_reset = 1'b1;
    always #5 clk = ~clk;

    dff_bank_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    dff_bank_arbiter #(.NUM_REQ(N), .DATA_W(W), .LOCK_MAX(LM)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    typedef struct {
        logic         valid;
        logic [W-1:0] q;
        int           owner;
        logic         to;
    } reg_exp_t;

    reg_exp_t         reg_q[$];
    logic [N-1:0]     gnt_q[$];
    int               checks = 0;
    int               passed = 0;

    // Reference model: who holds the bus, how many grants in a row it has had,
    // and where the next fair search starts.
    int       m_ptr    = 0;
    bit       m_locked = 1'b0;
    int       m_owner  = 0;
    int       m_run    = 0;
    reg_exp_t m_out    = '{valid: 1'b0, q: '0, owner: 0, to: 1'b0};
    bit       have_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    // Issue one cycle of stimulus and push what the DUT must show.
    task automatic drive(input bit rst, input logic [N-1:0] req,
                         input logic [N-1:0] lk, input logic [N*W-1:0] d);
        int g;
        logic [N-1:0] onehot;
        @(posedge clk); #1;
        if (have_prev) reg_q.push_back(m_out);
        sync_reset = rst;
        bus.req    = req;
        bus.lock   = lk;
        bus.d_in   = d;

        g = -1;
        if (!rst) begin
            if (m_locked && req[m_owner]) g = m_owner;
            else
                for (int k = 0; k < N; k++)
                    if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        onehot = '0;
        if (g >= 0) onehot[g] = 1'b1;
        gnt_q.push_back(onehot);

        if (rst) begin
            m_ptr = 0; m_locked = 1'b0; m_run = 0;
            m_out.valid = 1'b0; m_out.q = '0; m_out.owner = 0; m_out.to = 1'b0;
        end else begin
            m_out.to = 1'b0;
            if (g < 0) begin
                m_out.valid = 1'b0;
                m_locked    = 1'b0;
            end else begin
                m_out.valid = 1'b1;
                m_out.q     = d[g*W +: W];
                m_out.owner = g;
                m_ptr       = (g + 1) % N;
                if (m_locked && g == m_owner) begin
                    m_run++;
                    if (!lk[g]) m_locked = 1'b0;
                    else if (m_run >= LM) begin
                        m_locked = 1'b0;
                        m_out.to = 1'b1;
                    end
                end else if (lk[g] && LM > 1) begin
                    m_locked = 1'b1; m_owner = g; m_run = 1;
                end else begin
                    m_locked = 1'b0;
                end
            end
        end
        have_prev = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against queued expectations.
    initial begin
        logic [N-1:0] eg;
        reg_exp_t     r;
        forever begin
            @(negedge clk);
            if (gnt_q.size() > 0) begin
                eg = gnt_q.pop_front();
                chk("gnt", 32'(bus.gnt), 32'(eg));
            end
            if (reg_q.size() > 0) begin
                r = reg_q.pop_front();
                chk("q_valid", 32'(bus.q_valid), 32'(r.valid));
                chk("q", 32'(bus.q), 32'(r.q));
                chk("q_owner", 32'(bus.q_owner), 32'(r.owner));
                chk("lock_timeout", 32'(bus.lock_timeout), 32'(r.to));
            end
        end
    end

    initial begin
        logic [N*W-1:0] dpat;
        logic [N-1:0]   rq, lk;
        dpat = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req = '1; bus.lock = '0; bus.d_in = dpat;

        // Reset with all requesting: no grants.
        repeat (2) drive(1'b1, 4'hF, 4'h0, dpat);
        // Full rotation.
        repeat (8) drive(1'b0, 4'hF, 4'h0, dpat);
        // Sparse requesters.
        repeat (6) drive(1'b0, 4'b0101, 4'h0, dpat);
        // Lock held by requester 1 until timeout.
        drive(1'b1, 4'hF, 4'h0, dpat);
        repeat (7) drive(1'b0, 4'hF, 4'b0010, dpat);
        // Lock owner drops its request.
        drive(1'b1, 4'h0, 4'h0, dpat);
        drive(1'b0, 4'b0010, 4'b0010, dpat);
        repeat (2) drive(1'b0, 4'b1001, 4'h0, dpat);
        // Reset in the middle of a lock.
        drive(1'b1, 4'h0, 4'h0, dpat);
        repeat (3) drive(1'b0, 4'hF, 4'b0100, dpat);
        drive(1'b1, 4'hF, 4'b0100, dpat);
        repeat (4) drive(1'b0, 4'hF, 4'h0, dpat);

        // Randomized traffic with lock-heavy stretches and rare resets.
        for (int c = 0; c < 1500; c++) begin
            rq = 4'($urandom);
            if ($urandom_range(0, 3) == 0) rq = 4'hF;
            lk = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom & $urandom);
            drive($urandom_range(0, 63) == 0, rq, lk, 32'($urandom));
        end

        @(posedge clk); #1;
        reg_q.push_back(m_out);
        repeat (2) @(negedge clk);
        #1;
        chk("queue_drain", 32'(reg_q.size() + gnt_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
